// File: rtl/centroid_div_ctrl.sv
// rtl/centroid_div_ctrl.sv - per-frame centroid sequencer sharing one restoring divider for SX/S and SY/S
module centroid_div_ctrl #(
    parameter int SUM_S_WIDTH  = 20,
    parameter int SUM_XY_WIDTH = 28
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    iEN,
    input  logic                    iVSYNC,
    input  logic [SUM_S_WIDTH-1:0]  iSUM_S,
    input  logic [SUM_XY_WIDTH-1:0] iSUM_SX,
    input  logic [SUM_XY_WIDTH-1:0] iSUM_SY,
    input  logic                    iOVR_CLR,
    output logic [SUM_XY_WIDTH-1:0] oQUOTIENT_SX,
    output logic [SUM_XY_WIDTH-1:0] oQUOTIENT_SY,
    output logic                    oVALID,
    output logic                    oBUSY,
    output logic                    oDIV0,
    output logic                    oOVERRUN
);
    localparam int SW = SUM_S_WIDTH;
    localparam int XW = SUM_XY_WIDTH;
    localparam int CW = $clog2(XW);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

    state_t          state_q, state_d;
    logic            vs_q;
    logic [SW-1:0]   s_q, s_d;
    logic [XW-1:0]   dvd_q, dvd_d;
    logic [XW-1:0]   sy_q, sy_d;
    logic [XW-1:0]   qx_q, qx_d;
    logic [SW:0]     rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div0_q, div0_d;
    logic [XW-1:0]   qsx_q, qsx_d;
    logic [XW-1:0]   qsy_q, qsy_d;
    logic            valid_q, valid_d;
    logic            odiv0_q, odiv0_d;
    logic            ovr_q, ovr_d;

    logic            start;
    logic            busy;
    logic            last_bit;
    logic            fits;
    logic [SW:0]     shifted;
    logic [SW:0]     rem_step;
    logic [XW-1:0]   dvd_step;

    assign start    = iVSYNC & ~vs_q & iEN;
    assign busy     = (state_q != IDLE);
    assign last_bit = (cnt_q == CW'(XW - 1));

    // rem_q never exceeds S-1, so a set top bit could only mean rem' > S anyway
    assign shifted  = {rem_q[SW-1:0], dvd_q[XW-1]};
    assign fits     = rem_q[SW] | (shifted >= {1'b0, s_q});
    assign rem_step = fits ? (shifted - {1'b0, s_q}) : shifted;
    assign dvd_step = {dvd_q[XW-2:0], fits};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (iSUM_S == '0) ? DONE : DIV_X;
            DIV_X:   if (last_bit) state_d = DIV_Y;
            DIV_Y:   if (last_bit) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_d     = s_q;
        dvd_d   = dvd_q;
        sy_d    = sy_q;
        qx_d    = qx_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        div0_d  = div0_q;
        qsx_d   = qsx_q;
        qsy_d   = qsy_q;
        valid_d = 1'b0;
        odiv0_d = odiv0_q;
        ovr_d   = (start & busy) ? 1'b1 : (iOVR_CLR ? 1'b0 : ovr_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d    = iSUM_S;
                    dvd_d  = iSUM_SX;
                    sy_d   = iSUM_SY;
                    rem_d  = '0;
                    cnt_d  = '0;
                    div0_d = (iSUM_S == '0);
                end
            end
            DIV_X, DIV_Y: begin
                rem_d = rem_step;
                dvd_d = dvd_step;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    rem_d = '0;
                    cnt_d = '0;
                    // the SY quotient is built in place, so the SX result is parked first
                    if (state_q == DIV_X) begin
                        qx_d  = dvd_step;
                        dvd_d = sy_q;
                    end
                end
            end
            default: begin
                qsx_d   = div0_q ? '0 : qx_q;
                qsy_d   = div0_q ? '0 : dvd_q;
                odiv0_d = div0_q;
                valid_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vs_q    <= 1'b1;
            s_q     <= '0;
            dvd_q   <= '0;
            sy_q    <= '0;
            qx_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            div0_q  <= 1'b0;
            qsx_q   <= '0;
            qsy_q   <= '0;
            valid_q <= 1'b0;
            odiv0_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            vs_q    <= iVSYNC;
            s_q     <= s_d;
            dvd_q   <= dvd_d;
            sy_q    <= sy_d;
            qx_q    <= qx_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            div0_q  <= div0_d;
            qsx_q   <= qsx_d;
            qsy_q   <= qsy_d;
            valid_q <= valid_d;
            odiv0_q <= odiv0_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        oQUOTIENT_SX = qsx_q;
        oQUOTIENT_SY = qsy_q;
        oVALID       = valid_q;
        oBUSY        = busy;
        oDIV0        = odiv0_q;
        oOVERRUN     = ovr_q;
    end
endmodule

// File: tb/tb_centroid_div_ctrl.sv
// tb/tb_centroid_div_ctrl.sv - directed self-checking bench for centroid_div_ctrl
module tb_centroid_div_ctrl;
    logic        CLK = 1'b0;
    logic        RST, iEN, iVSYNC, iOVR_CLR;
    logic [19:0] iSUM_S;
    logic [27:0] iSUM_SX, iSUM_SY;
    logic [27:0] oQUOTIENT_SX, oQUOTIENT_SY;
    logic        oVALID, oBUSY, oDIV0, oOVERRUN;

    int checks = 0;
    int failures = 0;

    centroid_div_ctrl dut (
        .CLK(CLK), .RST(RST), .iEN(iEN), .iVSYNC(iVSYNC),
        .iSUM_S(iSUM_S), .iSUM_SX(iSUM_SX), .iSUM_SY(iSUM_SY), .iOVR_CLR(iOVR_CLR),
        .oQUOTIENT_SX(oQUOTIENT_SX), .oQUOTIENT_SY(oQUOTIENT_SY),
        .oVALID(oVALID), .oBUSY(oBUSY), .oDIV0(oDIV0), .oOVERRUN(oOVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Rise iVSYNC at edge 0, scramble the sums afterwards, then watch 70 edges for oVALID.
    task automatic frame(input logic [19:0] s, input logic [27:0] sx, input logic [27:0] sy,
                         output int vat, output int npulse, output logic busy0);
        iSUM_S = s; iSUM_SX = sx; iSUM_SY = sy; iVSYNC = 1'b1;
        tick();
        busy0 = oBUSY;
        iVSYNC = 1'b0; iSUM_S = ~s; iSUM_SX = ~sx; iSUM_SY = ~sy;
        vat = -1; npulse = 0;
        for (int e = 1; e <= 70; e++) begin
            tick();
            if (oVALID) begin
                npulse++;
                if (vat < 0) vat = e;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; iEN = 1'b1; iVSYNC = 1'b0; iOVR_CLR = 1'b0;
        iSUM_S = '0; iSUM_SX = '0; iSUM_SY = '0;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        checks++;
        if ({oQUOTIENT_SX, oQUOTIENT_SY, oVALID, oBUSY, oDIV0, oOVERRUN} !== 60'd0) begin
            failures++;
            $display("FAIL reset_state got qx=%0h qy=%0h v=%b b=%b d0=%b ovr=%b want all 0",
                     oQUOTIENT_SX, oQUOTIENT_SY, oVALID, oBUSY, oDIV0, oOVERRUN);
        end
    endtask

    task automatic test_nominal();
        int vat, np; logic b0;
        frame(20'd10, 28'd1000, 28'd2000, vat, np, b0);
        checks++;
        if (b0 !== 1'b1) begin failures++; $display("FAIL nominal_busy got=%b want=1", b0); end
        checks++;
        if (vat !== 57 || np !== 1) begin
            failures++; $display("FAIL nominal_latency got edge=%0d pulses=%0d want edge=57 pulses=1", vat, np);
        end
        checks++;
        if (oQUOTIENT_SX !== 28'd100 || oQUOTIENT_SY !== 28'd200 || oDIV0 !== 1'b0 || oBUSY !== 1'b0) begin
            failures++; $display("FAIL nominal_result got qx=%0d qy=%0d d0=%b b=%b want 100 200 0 0",
                                 oQUOTIENT_SX, oQUOTIENT_SY, oDIV0, oBUSY);
        end
    endtask

    task automatic test_truncation();
        int vat, np; logic b0;
        logic [19:0] ts [3] = '{20'd2, 20'd1, 20'hFFFFF};
        logic [27:0] tx [3] = '{28'd7, 28'hFFFFFFF, 28'hFFFFE};
        logic [27:0] ty [3] = '{28'd0, 28'hFFFFFFF, 28'd5};
        logic [27:0] ex [3] = '{28'd3, 28'hFFFFFFF, 28'd0};
        logic [27:0] ey [3] = '{28'd0, 28'hFFFFFFF, 28'd0};
        for (int i = 0; i < 3; i++) begin
            frame(ts[i], tx[i], ty[i], vat, np, b0);
            checks++;
            if (vat !== 57 || oQUOTIENT_SX !== ex[i] || oQUOTIENT_SY !== ey[i]) begin
                failures++;
                $display("FAIL trunc_%0d got edge=%0d qx=%0h qy=%0h want edge=57 qx=%0h qy=%0h",
                         i, vat, oQUOTIENT_SX, oQUOTIENT_SY, ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_div0();
        int vat, np; logic b0;
        frame(20'd0, 28'd123, 28'd456, vat, np, b0);
        checks++;
        if (vat !== 1 || np !== 1 || oQUOTIENT_SX !== 28'd0 || oQUOTIENT_SY !== 28'd0 || oDIV0 !== 1'b1) begin
            failures++;
            $display("FAIL div0 got edge=%0d pulses=%0d qx=%0h qy=%0h d0=%b want 1 1 0 0 1",
                     vat, np, oQUOTIENT_SX, oQUOTIENT_SY, oDIV0);
        end
        frame(20'd4, 28'd8, 28'd0, vat, np, b0);
        checks++;
        if (vat !== 57 || oQUOTIENT_SX !== 28'd2 || oQUOTIENT_SY !== 28'd0 || oDIV0 !== 1'b0) begin
            failures++;
            $display("FAIL div0_recover got edge=%0d qx=%0h qy=%0h d0=%b want 57 2 0 0",
                     vat, oQUOTIENT_SX, oQUOTIENT_SY, oDIV0);
        end
    endtask

    task automatic test_overrun();
        int vat = -1;
        iSUM_S = 20'd6; iSUM_SX = 28'd600; iSUM_SY = 28'd60; iVSYNC = 1'b1;
        tick();
        iVSYNC = 1'b0;
        for (int e = 1; e <= 19; e++) tick();
        iSUM_S = 20'd3; iSUM_SX = 28'd9; iSUM_SY = 28'd9; iVSYNC = 1'b1;
        tick();
        iVSYNC = 1'b0;
        checks++;
        if (oOVERRUN !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b want=1", oOVERRUN); end
        for (int e = 21; e <= 70; e++) begin
            tick();
            if (oVALID && vat < 0) vat = e;
        end
        checks++;
        if (vat !== 57 || oQUOTIENT_SX !== 28'd100 || oQUOTIENT_SY !== 28'd10 || oOVERRUN !== 1'b1) begin
            failures++;
            $display("FAIL overrun_result got edge=%0d qx=%0d qy=%0d ovr=%b want 57 100 10 1",
                     vat, oQUOTIENT_SX, oQUOTIENT_SY, oOVERRUN);
        end
        iOVR_CLR = 1'b1;
        tick();
        iOVR_CLR = 1'b0;
        checks++;
        if (oOVERRUN !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b want=0", oOVERRUN); end
        iSUM_S = 20'd5; iSUM_SX = 28'd55; iSUM_SY = 28'd15; iVSYNC = 1'b1;
        tick();
        iVSYNC = 1'b0;
        repeat (5) tick();
        iVSYNC = 1'b1; iOVR_CLR = 1'b1;
        tick();
        iVSYNC = 1'b0; iOVR_CLR = 1'b0;
        checks++;
        if (oOVERRUN !== 1'b1) begin failures++; $display("FAIL overrun_set_wins got=%b want=1", oOVERRUN); end
        repeat (60) tick();
        checks++;
        if (oQUOTIENT_SX !== 28'd11 || oQUOTIENT_SY !== 28'd3) begin
            failures++; $display("FAIL overrun_frame2 got qx=%0d qy=%0d want 11 3", oQUOTIENT_SX, oQUOTIENT_SY);
        end
        iOVR_CLR = 1'b1;
        tick();
        iOVR_CLR = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nv = 0; int vat, np; logic b0;
        iSUM_S = 20'd10; iSUM_SX = 28'd1000; iSUM_SY = 28'd2000; iVSYNC = 1'b1;
        tick();
        iVSYNC = 1'b0;
        for (int e = 1; e <= 29; e++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (oBUSY !== 1'b0 || oQUOTIENT_SX !== 28'd0 || oQUOTIENT_SY !== 28'd0 || oOVERRUN !== 1'b0) begin
            failures++; $display("FAIL reset_mid got b=%b qx=%0h qy=%0h ovr=%b want 0 0 0 0",
                                 oBUSY, oQUOTIENT_SX, oQUOTIENT_SY, oOVERRUN);
        end
        for (int e = 0; e < 70; e++) begin
            tick();
            if (oVALID) nv++;
        end
        checks++;
        if (nv !== 0) begin failures++; $display("FAIL reset_mid_novalid got pulses=%0d want=0", nv); end
        frame(20'd7, 28'd70, 28'd700, vat, np, b0);
        checks++;
        if (vat !== 57 || oQUOTIENT_SX !== 28'd10 || oQUOTIENT_SY !== 28'd100) begin
            failures++; $display("FAIL reset_mid_next got edge=%0d qx=%0d qy=%0d want 57 10 100",
                                 vat, oQUOTIENT_SX, oQUOTIENT_SY);
        end
    endtask

    task automatic test_enable();
        int vat = -1;
        iEN = 1'b0; iSUM_S = 20'd1; iSUM_SX = 28'd1; iSUM_SY = 28'd1; iVSYNC = 1'b1;
        tick();
        checks++;
        if (oBUSY !== 1'b0) begin failures++; $display("FAIL en_off_start got busy=%b want=0", oBUSY); end
        iVSYNC = 1'b0; iEN = 1'b1;
        tick();
        iSUM_S = 20'd5; iSUM_SX = 28'd50; iSUM_SY = 28'd25; iVSYNC = 1'b1;
        tick();
        iVSYNC = 1'b0; iEN = 1'b0;
        for (int e = 1; e <= 70; e++) begin
            tick();
            if (oVALID && vat < 0) vat = e;
        end
        iEN = 1'b1;
        checks++;
        if (vat !== 57 || oQUOTIENT_SX !== 28'd10 || oQUOTIENT_SY !== 28'd5) begin
            failures++; $display("FAIL en_drop_midop got edge=%0d qx=%0d qy=%0d want 57 10 5",
                                 vat, oQUOTIENT_SX, oQUOTIENT_SY);
        end
    endtask

    task automatic test_vsync_held();
        int vat = -1;
        iSUM_S = 20'd3; iSUM_SX = 28'd30; iSUM_SY = 28'd3;
        iVSYNC = 1'b1; RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        repeat (4) tick();
        checks++;
        if (oBUSY !== 1'b0) begin failures++; $display("FAIL vsync_held got busy=%b want=0", oBUSY); end
        iVSYNC = 1'b0;
        tick();
        iVSYNC = 1'b1;
        tick();
        iVSYNC = 1'b0;
        checks++;
        if (oBUSY !== 1'b1) begin failures++; $display("FAIL vsync_new_edge got busy=%b want=1", oBUSY); end
        for (int e = 1; e <= 70; e++) begin
            tick();
            if (oVALID && vat < 0) vat = e;
        end
        checks++;
        if (vat !== 57 || oQUOTIENT_SX !== 28'd10 || oQUOTIENT_SY !== 28'd1) begin
            failures++; $display("FAIL vsync_frame got edge=%0d qx=%0d qy=%0d want 57 10 1",
                                 vat, oQUOTIENT_SX, oQUOTIENT_SY);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_truncation();
        test_div0();
        test_overrun();
        test_reset_mid();
        test_enable();
        test_vsync_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/centroid_div_ctrl.md
Name: centroid_div_ctrl

Overview:
- Per-frame centroid sequencer for the eye tracker.
- On each frame boundary it captures the accumulated pupil sums S, SX and SY.
- It time-shares one internal restoring serial divider to compute SX/S, then SY/S.
- It publishes the two quotients with a one-cycle valid strobe. These quotients feed the register block readback and the cursor overlay.

Parameters:
- SUM_S_WIDTH, 20, width of pixel-count sum S (divisor).
- SUM_XY_WIDTH, 28, width of SX/SY sums (dividends) and of both quotients.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- iEN  in  1  1 = start on frame boundary allowed; 0 = starts ignored (an in-flight operation still completes)
- iVSYNC  in  1  frame sync, level; a rising edge marks end of frame
- iSUM_S  in  SUM_S_WIDTH  pixel count sum
- iSUM_SX  in  SUM_XY_WIDTH  x-weighted sum
- iSUM_SY  in  SUM_XY_WIDTH  y-weighted sum
- iOVR_CLR  in  1  pulse; clears oOVERRUN
- oQUOTIENT_SX  out  SUM_XY_WIDTH  floor(SX/S) of last completed frame
- oQUOTIENT_SY  out  SUM_XY_WIDTH  floor(SY/S) of last completed frame
- oVALID  out  1  one-cycle pulse when quotients update
- oBUSY  out  1  high whenever state != IDLE
- oDIV0  out  1  1 = last completed frame had S == 0
- oOVERRUN  out  1  sticky; a start edge arrived while busy

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high; all registers are updated only on the CLK rising edge.
- Reset values:
  - Quotients 0; oVALID, oBUSY, oDIV0 and oOVERRUN all 0; state IDLE.
  - VSYNC delay register vs_d resets to 1, so no spurious edge is seen at reset release.
- Start condition: start = iVSYNC & ~vs_d & iEN. vs_d <= iVSYNC every cycle.
- States: IDLE, DIV_X, DIV_Y, DONE.
- IDLE, start seen at edge k:
  - Capture S, SX and SY into internal registers.
  - If S != 0, go to DIV_X. If S == 0, go to DONE with the div0 flag set.
- DIV_X: one quotient bit per cycle, MSB first, SUM_XY_WIDTH cycles (edges k+1..k+28 at default widths).
  - Remainder register is SUM_S_WIDTH+1 bits.
  - Each step: rem' = {rem, next dividend bit}. If rem' >= S, then rem = rem' - S and qbit = 1; otherwise rem = rem' and qbit = 0.
- DIV_Y: remainder and bit counter reinitialised, then same algorithm on SY (edges k+29..k+56).
- DONE (edge k+57, or k+1 for div0):
  - Load oQUOTIENT_SX/SY from the internal results, or load 0/0 for div0.
  - Load oDIV0 with the div0 flag.
  - Assert oVALID for exactly one cycle.
  - Return to IDLE.
- Latency: oVALID is visible 57 cycles after the capture edge (SUM_XY_WIDTH*2+1); 1 cycle in the div0 case.
- Quotients hold their value between oVALID pulses. The remainder is discarded (truncating division).
- Quotients never overflow: S >= 1, so Q <= dividend, which fits in SUM_XY_WIDTH bits.
- Start edge while oBUSY = 1: the edge is ignored (no recapture, no restart), and oOVERRUN is set.
  - A start edge coinciding with DONE counts as busy and is also ignored.
- oOVERRUN is cleared by iOVR_CLR. If set and clear occur in the same cycle, set wins.
- iEN deasserted mid-operation: no effect on the current division.
- RST asserted mid-operation: immediate return to IDLE with all outputs at reset values. No oVALID is produced for the aborted frame.
- iSUM_* are sampled only on the capture edge. Later changes to them do not affect the in-flight result.

Test Plan:
- Nominal: S=10, SX=1000, SY=2000, iVSYNC rises at edge 0 → oBUSY=1 from edge 0; oVALID single pulse at edge 57; QSX=100, QSY=200, oDIV0=0.
- Truncation and limits:
  - S=2, SX=7, SY=0 → QSX=3, QSY=0.
  - S=1, SX=SY=0xFFFFFFF → both quotients 0xFFFFFFF.
  - S=0xFFFFF, SX=0xFFFFE → QSX=0.
- Divide-by-zero: S=0 → oVALID at edge 1; quotients 0; oDIV0=1. Next frame with S=4, SX=8 → oDIV0=0, QSX=2.
- Overrun: second iVSYNC rising edge 20 cycles after start → result unchanged from the first capture; oOVERRUN=1 and held. Pulse iOVR_CLR → 0. iOVR_CLR coincident with a new overrun edge → stays 1.
- Reset mid-operation: RST high at cycle 30 of a division → next cycle oBUSY=0 and quotients 0; no oVALID is ever produced. A subsequent frame computes correctly.
- Enable and sync level:
  - iEN=0 during an iVSYNC rise → no start, oBUSY stays 0.
  - iVSYNC held high through reset release → no start until the next rising edge.
